render_scheduler: RTL and testbench

//  Sequences the framebuffer renderer and shares the main-RAM read port between the CPU and the renderer.
//  CPU draw/clear ops mark the display dirty; on the next vblank rising edge, once the CPU is between RAM accesses,
//  the block hands the port to the renderer, pulses its start, stalls the CPU until finished, then returns the port.

---
 rtl/render_scheduler.sv | 175 +++++++++++++++++
 tb/tb_render_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_scheduler.sv
// render_scheduler: sequences the framebuffer renderer and arbitrates the main-RAM
// read port between the CPU and the renderer, stalling the CPU while a frame renders.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   vblank           display vblank level (rising edge detected internally)
//   dirty_set        CPU pulse: screen memory changed, a render is needed
//   cpu_ram_busy     CPU RAM access in flight; handoff waits while high
//   cpu_ram_addr     CPU read address
//   rnd_ram_addr     renderer read address
//   rnd_finished     renderer done pulse (only honoured in RUN)
//   ram_read_addr    muxed address to main RAM
//   rnd_start        one-cycle start pulse to renderer
//   cpu_stall        holds the CPU from ARM through DONE
//   render_busy      high in GRANT, RUN and DONE
//   frames_rendered  completed renders (wraps)
//   frames_skipped   vblank edges seen while a render was in progress (wraps)
//   render_timeout   one-cycle pulse on watchdog abort
//
// Build option: define RENDER_WATCHDOG_EN to abort a render that runs for
// TIMEOUT_CYCLES cycles without rnd_finished; otherwise RUN waits forever.
module render_scheduler #(
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              vblank,
   input  logic              dirty_set,
   input  logic              cpu_ram_busy,
   input  logic [ADDR_W-1:0] cpu_ram_addr,
   input  logic [ADDR_W-1:0] rnd_ram_addr,
   input  logic              rnd_finished,
   output logic [ADDR_W-1:0] ram_read_addr,
   output logic              rnd_start,
   output logic              cpu_stall,
   output logic              render_busy,
   output logic [CNT_W-1:0]  frames_rendered,
   output logic [CNT_W-1:0]  frames_skipped,
   output logic              render_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_GRANT,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic             pending_q, pending_d;
   logic             owner_q, owner_d;
   logic             vblank_q;
   logic [CNT_W-1:0] rendered_q, rendered_d;
   logic [CNT_W-1:0] skipped_q, skipped_d;
   logic             vb_rise;
   logic             timeout;

   // A watchdog shorter than two cycles could never see the RUN state.
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   assign vb_rise = vblank & ~vblank_q;

`ifdef RENDER_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [WD_W-1:0] wd_q, wd_d;

   // Cleared in GRANT so the first RUN cycle counts as zero; the abort
   // therefore fires TIMEOUT_CYCLES cycles after GRANT.
   always_comb begin
      wd_d = wd_q;
      if (state_q == S_GRANT) begin
         wd_d = '0;
      end else if (state_q == S_RUN) begin
         wd_d = wd_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end

   assign timeout = (state_q == S_RUN) && !rnd_finished &&
                    (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q | dirty_set;
      owner_d    = owner_q;
      rendered_d = rendered_q;
      skipped_d  = skipped_q;

      // Edges that arrive while a render is in flight are only counted.
      if (vb_rise && (state_q != S_IDLE)) begin
         skipped_d = skipped_q + 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (vb_rise && pending_q) begin
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (!cpu_ram_busy) begin
               state_d = S_GRANT;
               owner_d = 1'b1;
            end
         end
         S_GRANT: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (rnd_finished) begin
               state_d = S_DONE;
               owner_d = 1'b0;
            end else if (timeout) begin
               // Abort keeps pending so the frame is retried next vblank.
               state_d = S_IDLE;
               owner_d = 1'b0;
            end
         end
         S_DONE: begin
            state_d    = S_IDLE;
            rendered_d = rendered_q + 1'b1;
            pending_d  = dirty_set;
         end
         default: begin
            state_d = S_IDLE;
            owner_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         pending_q  <= 1'b0;
         owner_q    <= 1'b0;
         vblank_q   <= 1'b0;
         rendered_q <= '0;
         skipped_q  <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         owner_q    <= owner_d;
         vblank_q   <= vblank;
         rendered_q <= rendered_d;
         skipped_q  <= skipped_d;
      end
   end

   assign ram_read_addr   = owner_q ? rnd_ram_addr : cpu_ram_addr;
   assign rnd_start       = (state_q == S_GRANT);
   assign cpu_stall       = (state_q != S_IDLE);
   assign render_busy     = (state_q == S_GRANT) ||
                            (state_q == S_RUN) ||
                            (state_q == S_DONE);
   assign frames_rendered = rendered_q;
   assign frames_skipped  = skipped_q;
   assign render_timeout  = timeout;

endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler: directed bench for render_scheduler.
// Expected rnd_start cycles are queued at stimulus time and checked by a monitor.
module tb_render_scheduler;

   localparam int AW = 12;
   localparam int CW = 16;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          vblank = 1'b0;
   logic          dirty_set = 1'b0;
   logic          cpu_ram_busy = 1'b0;
   logic          rnd_finished = 1'b0;
   logic [AW-1:0] cpu_ram_addr = 12'h055;
   logic [AW-1:0] rnd_ram_addr = 12'h100;
   logic [AW-1:0] ram_read_addr;
   logic          rnd_start;
   logic          cpu_stall;
   logic          render_busy;
   logic          render_timeout;
   logic [CW-1:0] frames_rendered;
   logic [CW-1:0] frames_skipped;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int exp_q[$];

   render_scheduler #(
      .ADDR_W(AW),
      .TIMEOUT_CYCLES(TO),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .vblank(vblank),
      .dirty_set(dirty_set),
      .cpu_ram_busy(cpu_ram_busy),
      .cpu_ram_addr(cpu_ram_addr),
      .rnd_ram_addr(rnd_ram_addr),
      .rnd_finished(rnd_finished),
      .ram_read_addr(ram_read_addr),
      .rnd_start(rnd_start),
      .cpu_stall(cpu_stall),
      .render_busy(render_busy),
      .frames_rendered(frames_rendered),
      .frames_skipped(frames_skipped),
      .render_timeout(render_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Each start pulse must match the next queued expected cycle.
   always @(negedge clk) begin
      if (reset_n && (rnd_start === 1'b1)) begin
         if (exp_q.size() == 0) begin
            chk("start_unexpected", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            chk("start_cycle", 32'(cyc), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      // Reset state
      step(2);
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      chk("rst_start", 32'(rnd_start), 32'd0);
      chk("rst_busy", 32'(render_busy), 32'd0);
      chk("rst_rend", 32'(frames_rendered), 32'd0);
      chk("rst_skip", 32'(frames_skipped), 32'd0);
      chk("rst_tmo", 32'(render_timeout), 32'd0);
      chk("rst_mux", 32'(ram_read_addr), 32'h055);
      reset_n = 1'b1;
      step(2);

      // vblank rise with nothing pending
      vblank = 1'b1;
      step(1);
      chk("nopend_stall1", 32'(cpu_stall), 32'd0);
      step(2);
      chk("nopend_stall3", 32'(cpu_stall), 32'd0);
      chk("nopend_busy", 32'(render_busy), 32'd0);
      chk("nopend_rend", 32'(frames_rendered), 32'd0);
      chk("nopend_skip", 32'(frames_skipped), 32'd0);
      vblank = 1'b0;
      step(1);

      // Basic render: start two cycles after the edge
      dirty_set = 1'b1;
      step(1);
      dirty_set = 1'b0;
      step(1);
      vblank = 1'b1;
      exp_q.push_back(cyc + 2);
      step(1);
      chk("arm_stall", 32'(cpu_stall), 32'd1);
      chk("arm_busy", 32'(render_busy), 32'd0);
      chk("arm_mux", 32'(ram_read_addr), 32'h055);
      step(1);
      chk("grant_busy", 32'(render_busy), 32'd1);
      chk("grant_mux", 32'(ram_read_addr), 32'h100);
      step(1);
      chk("run_start", 32'(rnd_start), 32'd0);

      // Renderer owns the port across its address range
      for (int a = 12'h100; a <= 12'h1FF; a++) begin
         rnd_ram_addr = AW'(a);
         #1;
         chk("rnd_mux", 32'(ram_read_addr), 32'(a));
         step(1);
      end
      chk("run_stall", 32'(cpu_stall), 32'd1);
      rnd_finished = 1'b1;
      step(1);
      rnd_finished = 1'b0;
      chk("done_mux", 32'(ram_read_addr), 32'h055);
      chk("done_stall", 32'(cpu_stall), 32'd1);
      chk("done_busy", 32'(render_busy), 32'd1);
      step(1);
      chk("idle_stall", 32'(cpu_stall), 32'd0);
      chk("idle_busy", 32'(render_busy), 32'd0);
      chk("rend_1", 32'(frames_rendered), 32'd1);
      chk("skip_0", 32'(frames_skipped), 32'd0);
      rnd_finished = 1'b1;
      step(1);
      rnd_finished = 1'b0;
      chk("stray_fin", 32'(frames_rendered), 32'd1);
      vblank = 1'b0;
      step(1);

      // CPU busy holds the handoff in ARM
      cpu_ram_busy = 1'b1;
      dirty_set = 1'b1;
      step(1);
      dirty_set = 1'b0;
      vblank = 1'b1;
      step(1);
      for (int i = 0; i < 5; i++) begin
         cpu_ram_addr = AW'(12'h200 + i);
         #1;
         chk("busy_mux", 32'(ram_read_addr), 32'(12'h200 + i));
         chk("busy_stall", 32'(cpu_stall), 32'd1);
         chk("busy_nostart", 32'(rnd_start), 32'd0);
         step(1);
      end
      cpu_ram_busy = 1'b0;
      exp_q.push_back(cyc + 1);
      step(1);
      chk("busy_grant", 32'(render_busy), 32'd1);
      step(3);
      rnd_finished = 1'b1;
      step(1);
      rnd_finished = 1'b0;
      step(1);
      chk("rend_2", 32'(frames_rendered), 32'd2);
      vblank = 1'b0;
      step(1);

      // Skip during RUN, dirty_set in DONE keeps pending
      dirty_set = 1'b1;
      step(1);
      dirty_set = 1'b0;
      vblank = 1'b1;
      exp_q.push_back(cyc + 2);
      step(3);
      vblank = 1'b0;
      step(1);
      vblank = 1'b1;
      step(1);
      chk("skip_1", 32'(frames_skipped), 32'd1);
      rnd_finished = 1'b1;
      step(1);
      rnd_finished = 1'b0;
      dirty_set = 1'b1;
      step(1);
      dirty_set = 1'b0;
      chk("rend_3", 32'(frames_rendered), 32'd3);
      chk("skip_keep", 32'(frames_skipped), 32'd1);
      vblank = 1'b0;
      step(1);
      vblank = 1'b1;
      exp_q.push_back(cyc + 2);
      step(3);
      chk("rerender_busy", 32'(render_busy), 32'd1);
      rnd_finished = 1'b1;
      step(1);
      rnd_finished = 1'b0;
      step(1);
      chk("rend_4", 32'(frames_rendered), 32'd4);
      vblank = 1'b0;
      step(1);

`ifdef RENDER_WATCHDOG_EN
      // Watchdog abort 16 cycles after GRANT, pending retained
      dirty_set = 1'b1;
      step(1);
      dirty_set = 1'b0;
      vblank = 1'b1;
      exp_q.push_back(cyc + 2);
      step(2);
      for (int k = 1; k < TO; k++) begin
         step(1);
         chk("wd_quiet", 32'(render_timeout), 32'd0);
      end
      step(1);
      chk("wd_pulse", 32'(render_timeout), 32'd1);
      step(1);
      chk("wd_after", 32'(render_timeout), 32'd0);
      chk("wd_stall", 32'(cpu_stall), 32'd0);
      chk("wd_rend", 32'(frames_rendered), 32'd4);
      vblank = 1'b0;
      step(1);
      vblank = 1'b1;
      exp_q.push_back(cyc + 2);
      step(3);
      rnd_finished = 1'b1;
      step(1);
      rnd_finished = 1'b0;
      step(1);
      chk("wd_retry", 32'(frames_rendered), 32'd5);
      vblank = 1'b0;
      step(1);
`endif

      // Reset mid-render drops ownership at once
      dirty_set = 1'b1;
      step(1);
      dirty_set = 1'b0;
      vblank = 1'b1;
      exp_q.push_back(cyc + 2);
      step(3);
      chk("mid_owner", 32'(ram_read_addr), 32'(rnd_ram_addr));
      reset_n = 1'b0;
      #1;
      chk("mid_rst_mux", 32'(ram_read_addr), 32'(cpu_ram_addr));
      chk("mid_rst_stall", 32'(cpu_stall), 32'd0);
      chk("mid_rst_rend", 32'(frames_rendered), 32'd0);
      chk("mid_rst_skip", 32'(frames_skipped), 32'd0);
      step(2);
      reset_n = 1'b1;
      step(3);
      chk("start_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
